sync_fifo_flags: RTL and testbench
==================================

# sync_fifo_flags

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It uses all DEPTH entries and supports any DEPTH ≥ 2, not only powers of two. It adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain.

## Interface
- WIDTH, 8, data width in bits (≥ 1)
- DEPTH, 8, number of storage entries (≥ 2; any integer)
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- CW (localparam), $clog2(DEPTH+1), count width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- din  in  WIDTH  write data
- rd_en  in  1  read request
- err_clr  in  1  synchronous clear of overflow/underflow
- dout  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- State is held in registers: wr_ptr, rd_ptr (each 0..DEPTH-1), count (0..DEPTH), dout register (standard mode), err flags, and the memory array.
- Pointers advance by 1 and wrap from DEPTH-1 to 0 by explicit compare, not modulo 2^n.
- rd_acc = rd_en & !empty.
- wr_acc = wr_en & (!full | rd_acc). A write into a full FIFO is accepted when a read is accepted in the same cycle.
- Empty with wr_en & rd_en: the read is rejected (underflow set), the write is accepted, and count becomes 1.
- count_next = count + wr_acc - rd_acc. full, empty, almost_full and almost_empty are decoded combinationally from the registered count.
- Standard mode (FWFT=0): on rd_acc, dout <= mem[rd_ptr]. Otherwise dout holds its value.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] combinationally while !empty, and 0 while empty. rd_acc consumes the displayed word.
- overflow is set on wr_en & !wr_acc. underflow is set on rd_en & empty.
- err_clr clears both error flags. If a new error occurs in the same cycle as err_clr, the set wins.
- Rejected operations change no pointer, count or memory.
- The memory array is not reset.

## Timing
- Reset (asynchronous assert, synchronous release):
  - wr_ptr = rd_ptr = 0, count = 0, dout = 0
  - empty = 1, full = 0, almost_empty = 1, overflow = 0, underflow = 0
  - almost_full = 0
- Reset mid-operation discards all contents immediately. The first write after release lands at entry 0.
- Write latency: data written at edge N is readable from the cycle after edge N. empty deasserts and count increments after edge N.
- Standard read latency: rd_acc sampled at edge N, and dout is valid after edge N (one cycle).
- FWFT read latency: zero. The head word is on dout whenever !empty, and the next word appears after the consuming edge.
- All flags and count update on the same edge as the accepted operation; there is no extra cycle of lag.
- Simultaneous read and write with 0 < count < DEPTH: count unchanged, both pointers advance.

## Test plan
- Fill/drain, DEPTH=5, FWFT=0:
  - Stimulus: write 0x11..0x55, then read 5.
  - full=1 and count=5 after the 5th write.
  - dout reads 0x11..0x55, each one cycle after its rd_en.
  - empty=1 at the end; no error flags set.
- Wrap-around, DEPTH=5:
  - Stimulus: 3 writes, 3 reads, then 5 writes 0xA0..0xA4, then 5 reads.
  - Data returns in order across the pointer wrap at 4→0.
- Full with simultaneous read and write, DEPTH=8:
  - Stimulus: fill the FIFO, then wr_en=rd_en=1 for 3 cycles.
  - count stays 8, full stays 1, overflow=0.
  - Reads return the oldest 3 entries; the new words are read last.
- Errors:
  - Write while full with no read → overflow=1, count unchanged.
  - Read while empty → underflow=1.
  - Assert err_clr together with a new overflow → overflow remains 1.
  - err_clr alone → both flags return to 0.
- Thresholds and FWFT, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2, FWFT=1:
  - almost_empty drops after the 3rd write; almost_full rises after the 6th.
  - dout=0x11 is visible the cycle after the first write with no rd_en.
  - dout=0 whenever empty.
- Async reset:
  - Stimulus: assert rst mid-stream with count=4, off a clock edge.
  - Outputs reach their reset values immediately.
  - The next write followed by a read returns the new data, not stale entries.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock FIFO using all DEPTH entries (any DEPTH >= 2, not only powers
// of two). Provides an occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable read mode:
// FWFT=0 gives a registered read (data one cycle after rd_en), FWFT=1 shows
// the head word on dout combinationally whenever the FIFO is not empty.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous, active-high reset
//   wr_en, din    write request and data
//   rd_en         read request
//   err_clr       synchronous clear of overflow/underflow (a new error wins)
//   dout          read data
//   full, empty   count == DEPTH / count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
   parameter int  WIDTH    = 8,
   parameter int  DEPTH    = 8,
   parameter int  AF_LEVEL = DEPTH - 1,
   parameter int  AE_LEVEL = 1,
   parameter int  FWFT     = 0,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   input  logic             err_clr,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_next;
   logic             rd_acc;
   logic             wr_acc;

   // Status flags are pure decodes of the registered count, so they change
   // on the same edge as the operation that moved the count.
   assign full         = (count == FULL_CNT);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_CNT);
   assign almost_empty = (count <= AE_CNT);

   // A read frees a slot in the same cycle, so a full FIFO still accepts a
   // write paired with an accepted read. An empty FIFO never accepts a read,
   // even when a write arrives in the same cycle.
   assign rd_acc = rd_en & ~empty;
   assign wr_acc = wr_en & (~full | rd_acc);

   always_comb begin
      // NOTE: assign a default before the case so no path leaves count_next
      // unassigned; otherwise synthesis infers a latch.
      count_next = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of block order.
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // Explicit wrap compare: DEPTH need not be a power of two.
         if (wr_acc) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         count     <= count_next;
         // Set term is ORed after the clear so a fresh error beats err_clr.
         overflow  <= (wr_en & ~wr_acc) | (overflow  & ~err_clr);
         underflow <= (rd_en & empty)   | (underflow & ~err_clr);
      end
   end

   // NOTE: the storage array is deliberately left out of reset; empty/count
   // already mark its contents invalid, and an unreset array maps onto RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= din;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is shown directly; forced to zero while nothing is stored.
         assign dout = empty ? '0 : mem[rd_ptr];
      end else begin : g_std
         logic [WIDTH-1:0] dout_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)         dout_q <= '0;
            else if (rd_acc) dout_q <= mem[rd_ptr];
         end

         assign dout = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
//
// Two instances share clk/rst:
//   u_std : DEPTH=5, FWFT=0, default thresholds (AF=4, AE=1)
//   u_fw  : DEPTH=8, AF_LEVEL=6, AE_LEVEL=2, FWFT=1
// A queue-based reference model tracks both FIFOs. Inputs change on the
// falling edge; outputs are compared 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // ---- standard-mode instance ----
   logic       s_wr, s_rd, s_clr;
   logic [7:0] s_din, s_dout;
   logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
   logic [2:0] s_count;

   // ---- FWFT instance ----
   logic       f_wr, f_rd, f_clr;
   logic [7:0] f_din, f_dout;
   logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [3:0] f_count;

   sync_fifo_flags #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .wr_en(s_wr), .din(s_din), .rd_en(s_rd),
      .err_clr(s_clr), .dout(s_dout), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
      .overflow(s_ovf), .underflow(s_udf)
   );

   sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fw (
      .clk(clk), .rst(rst), .wr_en(f_wr), .din(f_din), .rd_en(f_rd),
      .err_clr(f_clr), .dout(f_dout), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ovf), .underflow(f_udf)
   );

   int n_checks = 0;
   int n_errors = 0;

   // ---- reference model ----
   logic [7:0] sq[$];
   logic [7:0] fq[$];
   logic [7:0] m_s_dout;
   logic       m_s_ovf, m_s_udf, m_f_ovf, m_f_udf;

   task automatic model_reset();
      sq.delete();
      fq.delete();
      m_s_dout = 8'h00;
      m_s_ovf  = 1'b0;
      m_s_udf  = 1'b0;
      m_f_ovf  = 1'b0;
      m_f_udf  = 1'b0;
   endtask

   // Expected output bundles: {full, empty, af, ae, ovf, udf, count, dout}
   function automatic logic [16:0] exp_s();
      int n = sq.size();
      return {n == 5, n == 0, n >= 4, n <= 1, m_s_ovf, m_s_udf, 3'(n), m_s_dout};
   endfunction

   function automatic logic [17:0] exp_f();
      int n = fq.size();
      logic [7:0] head = (n > 0) ? fq[0] : 8'h00;
      return {n == 8, n == 0, n >= 6, n <= 2, m_f_ovf, m_f_udf, 4'(n), head};
   endfunction

   // One clock for both instances: drive, clock, update model, settle.
   task automatic step(input logic sw, input logic [7:0] sd, input logic sr, input logic sc,
                       input logic fw, input logic [7:0] fd, input logic fr, input logic fc);
      int  n;
      bit  rok, wok;
      @(negedge clk);
      s_wr = sw; s_din = sd; s_rd = sr; s_clr = sc;
      f_wr = fw; f_din = fd; f_rd = fr; f_clr = fc;
      @(posedge clk);
      n   = sq.size();
      rok = sr && n > 0;
      wok = sw && (n < 5 || rok);
      if (rok) m_s_dout = sq.pop_front();
      if (wok) sq.push_back(sd);
      m_s_ovf = (sw && !wok) || (m_s_ovf && !sc);
      m_s_udf = (sr && n == 0) || (m_s_udf && !sc);
      n   = fq.size();
      rok = fr && n > 0;
      wok = fw && (n < 8 || rok);
      if (rok) void'(fq.pop_front());
      if (wok) fq.push_back(fd);
      m_f_ovf = (fw && !wok) || (m_f_ovf && !fc);
      m_f_udf = (fr && n == 0) || (m_f_udf && !fc);
      #1;
   endtask

   task automatic step_s(input logic w, input logic [7:0] d, input logic r, input logic c);
      step(w, d, r, c, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic step_f(input logic w, input logic [7:0] d, input logic r, input logic c);
      step(1'b0, 8'h00, 1'b0, 1'b0, w, d, r, c);
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      n_checks++;
      if ({s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_count, s_dout} !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00}) begin
         n_errors++;
         $display("FAIL reset_std: got f=%b e=%b af=%b ae=%b ov=%b un=%b cnt=%0d dout=%h, want 0 1 0 1 0 0 0 00",
                  s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_count, s_dout);
      end
      n_checks++;
      if ({f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_count, f_dout} !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00}) begin
         n_errors++;
         $display("FAIL reset_fwft: got f=%b e=%b af=%b ae=%b ov=%b un=%b cnt=%0d dout=%h, want 0 1 0 1 0 0 0 00",
                  f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_count, f_dout);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 5; i++) step_s(1'b1, 8'(8'h11 * i), 1'b0, 1'b0);
      n_checks++;
      if (s_full !== 1'b1 || s_count !== 3'd5) begin
         n_errors++;
         $display("FAIL fill_full: got full=%b count=%0d, want full=1 count=5", s_full, s_count);
      end
      for (int i = 1; i <= 5; i++) begin
         step_s(1'b0, 8'h00, 1'b1, 1'b0);
         n_checks++;
         if (s_dout !== 8'(8'h11 * i)) begin
            n_errors++;
            $display("FAIL drain_data[%0d]: got %h, want %h", i, s_dout, 8'(8'h11 * i));
         end
      end
      n_checks++;
      if (s_empty !== 1'b1 || s_ovf !== 1'b0 || s_udf !== 1'b0) begin
         n_errors++;
         $display("FAIL drain_end: got empty=%b ovf=%b udf=%b, want 1 0 0", s_empty, s_ovf, s_udf);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) step_s(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step_s(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step_s(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step_s(1'b0, 8'h00, 1'b1, 1'b0);
         n_checks++;
         if (s_dout !== 8'(8'hA0 + i)) begin
            n_errors++;
            $display("FAIL wrap_data[%0d]: got %h, want %h", i, s_dout, 8'(8'hA0 + i));
         end
      end
   endtask

   task automatic test_errors();
      for (int i = 0; i < 5; i++) step_s(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      step_s(1'b1, 8'h66, 1'b0, 1'b0);
      n_checks++;
      if (s_ovf !== 1'b1 || s_count !== 3'd5) begin
         n_errors++;
         $display("FAIL overflow_set: got ovf=%b count=%0d, want 1 5", s_ovf, s_count);
      end
      for (int i = 0; i < 5; i++) step_s(1'b0, 8'h00, 1'b1, 1'b0);
      step_s(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (s_udf !== 1'b1 || s_ovf !== 1'b1 || s_count !== 3'd0) begin
         n_errors++;
         $display("FAIL underflow_set: got udf=%b ovf=%b count=%0d, want 1 1 0", s_udf, s_ovf, s_count);
      end
      for (int i = 0; i < 5; i++) step_s(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      step_s(1'b1, 8'h77, 1'b0, 1'b1);
      n_checks++;
      if (s_ovf !== 1'b1 || s_udf !== 1'b0) begin
         n_errors++;
         $display("FAIL clr_vs_set: got ovf=%b udf=%b, want ovf=1 udf=0", s_ovf, s_udf);
      end
      step_s(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin
         n_errors++;
         $display("FAIL clr_alone: got ovf=%b udf=%b, want 0 0", s_ovf, s_udf);
      end
      for (int i = 0; i < 5; i++) begin
         step_s(1'b0, 8'h00, 1'b1, 1'b0);
         n_checks++;
         if (s_dout !== 8'(8'h70 + i)) begin
            n_errors++;
            $display("FAIL err_drain[%0d]: got %h, want %h", i, s_dout, 8'(8'h70 + i));
         end
      end
   endtask

   task automatic test_full_rdwr();
      logic [7:0] want [8];
      for (int i = 0; i < 8; i++) step_f(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step_f(1'b1, 8'(8'h90 + i), 1'b1, 1'b0);
         n_checks++;
         if (f_count !== 4'd8 || f_full !== 1'b1 || f_ovf !== 1'b0 || f_dout !== 8'(8'h31 + i)) begin
            n_errors++;
            $display("FAIL full_rdwr[%0d]: got count=%0d full=%b ovf=%b head=%h, want 8 1 0 %h",
                     i, f_count, f_full, f_ovf, f_dout, 8'(8'h31 + i));
         end
      end
      for (int i = 0; i < 5; i++) want[i] = 8'(8'h33 + i);
      for (int i = 0; i < 3; i++) want[5 + i] = 8'(8'h90 + i);
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (f_dout !== want[i]) begin
            n_errors++;
            $display("FAIL full_rdwr_drain[%0d]: got %h, want %h", i, f_dout, want[i]);
         end
         step_f(1'b0, 8'h00, 1'b1, 1'b0);
      end
   endtask

   task automatic test_thresholds();
      n_checks++;
      if (f_dout !== 8'h00 || f_empty !== 1'b1) begin
         n_errors++;
         $display("FAIL fwft_empty_start: got dout=%h empty=%b, want 00 1", f_dout, f_empty);
      end
      for (int k = 1; k <= 6; k++) begin
         step_f(1'b1, 8'(8'h11 * k), 1'b0, 1'b0);
         n_checks++;
         if (f_ae !== (k <= 2) || f_af !== (k >= 6) || f_dout !== 8'h11) begin
            n_errors++;
            $display("FAIL thresh[%0d]: got ae=%b af=%b dout=%h, want %b %b 11",
                     k, f_ae, f_af, f_dout, k <= 2, k >= 6);
         end
      end
      for (int k = 1; k <= 6; k++) begin
         step_f(1'b0, 8'h00, 1'b1, 1'b0);
         n_checks++;
         if (f_dout !== ((k < 6) ? 8'(8'h11 * (k + 1)) : 8'h00)) begin
            n_errors++;
            $display("FAIL fwft_drain[%0d]: got %h, want %h", k, f_dout,
                     (k < 6) ? 8'(8'h11 * (k + 1)) : 8'h00);
         end
      end
   endtask

   task automatic test_random();
      int wp;
      for (int c = 0; c < 600; c++) begin
         case (c / 150)
            0:       wp = 70;
            1:       wp = 30;
            2:       wp = 90;
            default: wp = 50;
         endcase
         step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) >= wp - 10,
              $urandom_range(0, 99) < 5,
              $urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) >= wp - 10,
              $urandom_range(0, 99) < 5);
         n_checks++;
         if ({s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_count, s_dout} !== exp_s()) begin
            n_errors++;
            $display("FAIL rand_std[%0d]: got %b, want %b", c,
                     {s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_count, s_dout}, exp_s());
         end
         n_checks++;
         if ({f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_count, f_dout} !== exp_f()) begin
            n_errors++;
            $display("FAIL rand_fwft[%0d]: got %b, want %b", c,
                     {f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_count, f_dout}, exp_f());
         end
      end
   endtask

   task automatic test_async_reset();
      while (sq.size() > 4) step_s(1'b0, 8'h00, 1'b1, 1'b0);
      while (sq.size() < 4) step_s(1'b1, 8'($urandom), 1'b0, 1'b0);
      n_checks++;
      if (s_count !== 3'd4) begin
         n_errors++;
         $display("FAIL pre_reset_count: got %0d, want 4", s_count);
      end
      @(negedge clk);
      s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0;
      f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if ({s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_count, s_dout} !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00}) begin
         n_errors++;
         $display("FAIL async_reset_std: got %b, want 01010000000000000",
                  {s_full, s_empty, s_af, s_ae, s_ovf, s_udf, s_count, s_dout});
      end
      n_checks++;
      if (f_count !== 4'd0 || f_empty !== 1'b1 || f_dout !== 8'h00) begin
         n_errors++;
         $display("FAIL async_reset_fwft: got count=%0d empty=%b dout=%h, want 0 1 00", f_count, f_empty, f_dout);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step_s(1'b1, 8'h5A, 1'b0, 1'b0);
      step_s(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (s_dout !== 8'h5A || s_empty !== 1'b1) begin
         n_errors++;
         $display("FAIL post_reset_data: got dout=%h empty=%b, want 5a 1", s_dout, s_empty);
      end
   endtask

   initial begin
      rst = 1'b1;
      s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0; s_din = 8'h00;
      f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_din = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_errors();
      test_full_rdwr();
      test_thresholds();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
